bus_arbiter_2m: RTL and testbench

BUS_ARBITER_2M -- requirements
Module: bus_arbiter_2m

---
 rtl/soc_bus_pkg.sv | 5 +
 rtl/bus_arbiter_2m_rr_pick2.sv | 8 +
 rtl/bus_arbiter_2m.sv | 66 ++++++
 tb/tb_bus_arbiter_2m.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared bus state encoding and default arbiter timeout
package soc_bus_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  localparam int TIMEOUT_CYCLES_DEF = 64;
endpackage

// File: rtl/bus_arbiter_2m_rr_pick2.sv
// rr_pick2: two-input round-robin selector, on a tie the master not granted last wins
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);
  assign win = &req ? ~last : req[1];
endmodule

// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: two-master round-robin arbiter in front of a single slave with timeout abort
module bus_arbiter_2m
  import soc_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic [1:0]  m_valid,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  input  logic [7:0]  m_wstrb,
  output logic [1:0]  m_ready,
  output logic [31:0] m_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        timeout_err
);
  state_t               state;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 win;
  logic                 active;
  logic                 done;
  logic                 tmo;

  rr_pick2 u_pick (.req(m_valid), .last(grant), .win(win));

  // A transaction is live only while the granted master still holds its request
  always_comb begin
    active  = (state == BUSY) && m_valid[grant];
    done    = active && s_ready;
    tmo     = active && !s_ready && (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    s_valid = active;
    s_addr  = grant ? m_addr[63:32]  : m_addr[31:0];
    s_wdata = grant ? m_wdata[63:32] : m_wdata[31:0];
    s_wstrb = active ? (grant ? m_wstrb[7:4] : m_wstrb[3:0]) : 4'b0000;
    m_ready = (done || tmo) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    m_rdata = done ? s_rdata : 32'd0;
  end

  // Arbitrate in IDLE, then hold BUSY until completion, timeout or master withdrawal
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state       <= IDLE;
      grant       <= 1'b1;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else if (state == IDLE) begin
      if (|m_valid) begin
        state <= BUSY;
        grant <= win;
        cnt   <= '0;
      end
    end else begin
      timeout_err <= timeout_err | tmo;
      if (!active || s_ready || tmo) state <= IDLE;
      else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb_bus_arbiter_2m: directed scenario checks for the two-master bus arbiter
module tb_bus_arbiter_2m;
  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic [1:0]  m_valid = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_wstrb = '0;
  logic [1:0]  m_ready;
  logic [31:0] m_rdata;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        grant;
  logic        timeout_err;
  int          errors = 0;
  int          checks = 0;

  bus_arbiter_2m dut (
    .clk(clk), .reset_(reset_), .m_valid(m_valid), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_ = 1'b0;
    m_valid = 2'b00;
    s_ready = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset_ = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL reset_grant got=%b exp=1", grant); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", timeout_err); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_svalid got=%b exp=0", s_valid); end
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL reset_mready got=%b exp=00", m_ready); end
    checks++; if (s_wstrb !== 4'b0000) begin errors++; $display("FAIL reset_swstrb got=%b exp=0000", s_wstrb); end
    reset_ = 1'b1;
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_ready;
    logic       exp_g;
    do_reset();
    m_addr  = {32'h0000_2000, 32'h0000_1000};
    m_wstrb = 8'h00;
    s_ready = 1'b1;
    s_rdata = 32'h0BAD_F00D;
    m_valid = 2'b11;
    #1;
    for (int i = 0; i < 5; i++) begin
      exp_g = 1'(i % 2);
      exp_ready = exp_g ? 2'b10 : 2'b01;
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rr_idle%0d s_valid got=%b exp=0", i, s_valid); end
      tick();
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, grant, exp_g); end
      checks++; if (m_ready !== exp_ready) begin errors++; $display("FAIL rr_ready%0d got=%b exp=%b", i, m_ready, exp_ready); end
      checks++; if (s_addr !== (exp_g ? 32'h2000 : 32'h1000)) begin errors++; $display("FAIL rr_addr%0d got=%h", i, s_addr); end
      tick();
    end
    m_valid = 2'b00;
    s_ready = 1'b0;
    tick();
  endtask

  task automatic test_single_read;
    do_reset();
    m_addr  = {32'hFFFF_FFFF, 32'h0000_0100};
    m_wstrb = 8'h00;
    m_valid = 2'b01;
    s_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rd_c0_svalid got=%b exp=0", s_valid); end
    tick();
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL rd_c1_svalid got=%b exp=1", s_valid); end
    checks++; if (s_addr !== 32'h100) begin errors++; $display("FAIL rd_c1_addr got=%h exp=100", s_addr); end
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL rd_c1_mready got=%b exp=00", m_ready); end
    checks++; if (m_rdata !== 32'd0) begin errors++; $display("FAIL rd_c1_rdata got=%h exp=0", m_rdata); end
    tick();
    s_ready = 1'b1;
    #1;
    checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL rd_c2_mready got=%b exp=01", m_ready); end
    checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_c2_rdata got=%h exp=deadbeef", m_rdata); end
    tick();
    m_valid = 2'b00;
    s_ready = 1'b0;
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rd_after_svalid got=%b exp=0", s_valid); end
  endtask

  task automatic test_write;
    do_reset();
    m_addr  = {32'h0000_0040, 32'h0000_0400};
    m_wdata = {32'hCAFE_F00D, 32'h1111_2222};
    m_wstrb = {4'b0011, 4'b1111};
    m_valid = 2'b10;
    s_rdata = 32'h1234_5678;
    tick();
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL wr_grant got=%b exp=1", grant); end
    checks++; if (s_wstrb !== 4'b0011) begin errors++; $display("FAIL wr_wstrb got=%b exp=0011", s_wstrb); end
    checks++; if (s_addr !== 32'h40) begin errors++; $display("FAIL wr_addr got=%h exp=40", s_addr); end
    checks++; if (s_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_wdata got=%h exp=cafef00d", s_wdata); end
    s_ready = 1'b1;
    #1;
    checks++; if (m_ready !== 2'b10) begin errors++; $display("FAIL wr_mready got=%b exp=10", m_ready); end
    tick();
    m_valid = 2'b00;
    s_ready = 1'b0;
    m_wstrb = 8'h00;
    #1;
  endtask

  task automatic test_timeout;
    int early = 0;
    do_reset();
    m_addr  = {32'h0, 32'h0000_0800};
    m_valid = 2'b01;
    s_rdata = 32'hA5A5_A5A5;
    tick();
    for (int i = 1; i < 64; i++) begin
      if (m_ready !== 2'b00) early++;
      tick();
    end
    checks++; if (early != 0) begin errors++; $display("FAIL tmo_early_ready got=%0d cycles exp=0", early); end
    checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL tmo_mready got=%b exp=01", m_ready); end
    checks++; if (m_rdata !== 32'd0) begin errors++; $display("FAIL tmo_rdata got=%h exp=0", m_rdata); end
    tick();
    m_valid = 2'b00;
    #1;
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_set got=%b exp=1", timeout_err); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL tmo_idle got=%b exp=0", s_valid); end
    tick();
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_err_held got=%b exp=1", timeout_err); end
  endtask

  task automatic test_coincide;
    do_reset();
    m_valid = 2'b01;
    s_rdata = 32'h7777_0001;
    tick();
    for (int i = 1; i < 64; i++) tick();
    s_ready = 1'b1;
    #1;
    checks++; if (m_ready !== 2'b01) begin errors++; $display("FAIL coin_mready got=%b exp=01", m_ready); end
    checks++; if (m_rdata !== 32'h7777_0001) begin errors++; $display("FAIL coin_rdata got=%h exp=77770001", m_rdata); end
    tick();
    m_valid = 2'b00;
    s_ready = 1'b0;
    tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL coin_err got=%b exp=0", timeout_err); end
  endtask

  task automatic test_drop;
    do_reset();
    m_valid = 2'b01;
    tick();
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL drop_busy got=%b exp=1", s_valid); end
    m_valid = 2'b00;
    #1;
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL drop_svalid got=%b exp=0", s_valid); end
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL drop_mready got=%b exp=00", m_ready); end
    tick();
    m_valid = 2'b10;
    tick();
    checks++; if (grant !== 1'b1 || s_valid !== 1'b1) begin errors++; $display("FAIL drop_rearb got=%b/%b exp=1/1", grant, s_valid); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL drop_err got=%b exp=0", timeout_err); end
    m_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_busy;
    do_reset();
    m_valid = 2'b11;
    tick();
    tick();
    reset_ = 1'b0;
    tick();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rstb_svalid got=%b exp=0", s_valid); end
    checks++; if (m_ready !== 2'b00) begin errors++; $display("FAIL rstb_mready got=%b exp=00", m_ready); end
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL rstb_grant got=%b exp=1", grant); end
    reset_ = 1'b1;
    tick();
    checks++; if (grant !== 1'b0 || s_valid !== 1'b1) begin errors++; $display("FAIL rstb_tie got=%b/%b exp=0/1", grant, s_valid); end
    m_valid = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_write();
    test_timeout();
    test_coincide();
    test_drop();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
